// File: rtl/apb_soc_ctrl_master_if.sv
// apb_soc_ctrl_master_if: command, response and APB3 bus signals of the APB initiator.
interface apb_soc_ctrl_master_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [APB_ADDR_WIDTH-1:0] req_addr_i;
  logic [31:0]               req_wdata_i;
  logic                      req_write_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [31:0]               rsp_rdata_o;
  logic                      rsp_err_o;
  logic                      busy_o;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;
  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i, PRDATA, PREADY, PSLVERR,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i, PRDATA, PREADY, PSLVERR,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_soc_ctrl_master.sv
// apb_soc_ctrl_master: single-outstanding APB3 initiator fed by a valid/ready command stream.
// Defining APB_MST_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_soc_ctrl_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  apb_soc_ctrl_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, next;
  logic accept, misaligned, complete, handshake, timeout;
  logic psel_d, penable_d, req_ready_d, rsp_valid_d, busy_d, err_d;
  logic [31:0] rdata_d;
  if (APB_ADDR_WIDTH < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
    $error("APB_ADDR_WIDTH must be >= 2 and TIMEOUT_CYCLES must fit the 8-bit counter");
  end
  assign misaligned = |bus.req_addr_i[1:0];
  assign accept     = state == IDLE && bus.req_valid_i;
  assign complete   = state == ACCESS && bus.PREADY;
  assign handshake  = state == RESP && bus.rsp_ready_i;
`ifdef APB_MST_TIMEOUT_EN
  logic [7:0] cnt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt <= '0;
    else if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && !bus.PREADY) cnt <= cnt + 8'd1;
  // PREADY in the expiry cycle takes the normal completion path
  assign timeout = state == ACCESS && !bus.PREADY && cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state           <= IDLE;
      bus.req_ready_o <= 1'b1;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_rdata_o <= '0;
      bus.rsp_err_o   <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
    end else begin
      state           <= next;
      bus.req_ready_o <= req_ready_d;
      bus.rsp_valid_o <= rsp_valid_d;
      bus.rsp_rdata_o <= rdata_d;
      bus.rsp_err_o   <= err_d;
      bus.busy_o      <= busy_d;
      bus.PSEL        <= psel_d;
      bus.PENABLE     <= penable_d;
      if (accept) begin
        bus.PADDR  <= APB_ADDR_WIDTH'(bus.req_addr_i);
        bus.PWDATA <= bus.req_wdata_i;
        bus.PWRITE <= bus.req_write_i;
      end
    end
  always_comb begin
    next = state == IDLE   ? (bus.req_valid_i ? (misaligned ? RESP : SETUP) : IDLE)
         : state == SETUP  ? ACCESS
         : state == ACCESS ? (complete || timeout ? RESP : ACCESS)
         : (bus.rsp_ready_i ? IDLE : RESP);
  end
  // Outputs are registered from the next state so they line up with the state register
  always_comb begin
    psel_d      = next == SETUP || next == ACCESS;
    penable_d   = next == ACCESS;
    req_ready_d = next == IDLE;
    rsp_valid_d = next == RESP;
    busy_d      = next != IDLE;
    rdata_d     = accept ? 32'h0 : complete ? (bus.PWRITE ? 32'h0 : bus.PRDATA)
                : timeout ? 32'hDEADBEEF : handshake ? 32'h0 : bus.rsp_rdata_o;
    err_d       = accept ? misaligned : complete ? bus.PSLVERR
                : timeout ? 1'b1 : handshake ? 1'b0 : bus.rsp_err_o;
  end
endmodule

// File: tb/tb_apb_soc_ctrl_master.sv
// tb_apb_soc_ctrl_master: vector table, random transactions against a transaction-level model,
// plus reset-mid-access and (with APB_MST_TIMEOUT_EN) timeout sequences.
module tb_apb_soc_ctrl_master;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  always #5 HCLK = ~HCLK;

  apb_soc_ctrl_master_if #(.APB_ADDR_WIDTH(12)) bus ();
  apb_soc_ctrl_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus.master)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        write;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_psel;
    int          exp_pen;
  } vec_t;

  typedef struct {
    int          lat, psel, pen;
    logic [31:0] rdata;
    logic        err, busy, rdy_before, bus_bad, stall_bad, after_valid, after_ready;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Transaction-level expectation: what a caller should see for one command
  function automatic vec_t model(input vec_t v);
    logic mis = v.addr[1:0] != 2'b00;
    v.exp_rdata = (mis || v.write) ? 32'h0 : v.prdata;
    v.exp_err   = mis || v.slverr;
    v.exp_lat   = mis ? 1 : 3 + v.waits;
    v.exp_psel  = mis ? 0 : 2 + v.waits;
    v.exp_pen   = mis ? 0 : 1 + v.waits;
    return v;
  endfunction

  // Issue one command, act as the slave, stall the response, then consume it
  task automatic run_txn(input vec_t v, output obs_t o);
    int cyc = 1;
    int k = 0;
    o = '{default: 0};
    @(negedge HCLK);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = v.addr;
    bus.req_wdata_i = v.wdata;
    bus.req_write_i = v.write;
    bus.rsp_ready_i = 1'b0;
    o.rdy_before = bus.req_ready_o;
    @(negedge HCLK);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 12'($urandom);
    bus.req_wdata_i = $urandom;
    bus.req_write_i = 1'($urandom);
    while (!bus.rsp_valid_o && cyc < 64) begin
      if (bus.PSEL) begin
        o.psel++;
        if (bus.PADDR !== v.addr || bus.PWDATA !== v.wdata || bus.PWRITE !== v.write) o.bus_bad = 1'b1;
      end
      if (bus.PENABLE && !bus.PSEL) o.bus_bad = 1'b1;
      if (bus.PENABLE) begin
        o.pen++;
        bus.PREADY  = k == v.waits;
        bus.PRDATA  = k == v.waits ? v.prdata : $urandom;
        bus.PSLVERR = k == v.waits ? v.slverr : 1'($urandom);
        k++;
      end else begin
        bus.PREADY  = 1'($urandom);
        bus.PRDATA  = $urandom;
        bus.PSLVERR = 1'($urandom);
      end
      @(negedge HCLK);
      cyc++;
    end
    o.lat   = cyc;
    o.rdata = bus.rsp_rdata_o;
    o.err   = bus.rsp_err_o;
    o.busy  = bus.busy_o;
    for (int i = 0; i < v.hold; i++) begin
      if (!(bus.rsp_valid_o && bus.rsp_rdata_o === o.rdata && bus.rsp_err_o === o.err &&
            !bus.req_ready_o && !bus.PSEL && !bus.PENABLE && bus.busy_o)) o.stall_bad = 1'b1;
      bus.PREADY  = 1'($urandom);
      bus.PRDATA  = $urandom;
      bus.PSLVERR = 1'($urandom);
      @(negedge HCLK);
    end
    if (bus.PSEL || bus.PENABLE) o.stall_bad = 1'b1;
    bus.rsp_ready_i = 1'b1;
    @(negedge HCLK);
    bus.rsp_ready_i = 1'b0;
    bus.PREADY = 1'b0;
    o.after_valid = bus.rsp_valid_o;
    o.after_ready = bus.req_ready_o;
  endtask

  task automatic check_txn(input string tag, input vec_t v, input obs_t o);
    chk({tag, " ready_before"}, 32'(o.rdy_before), 32'd1);
    chk({tag, " latency"}, 32'(o.lat), 32'(v.exp_lat));
    chk({tag, " psel_cycles"}, 32'(o.psel), 32'(v.exp_psel));
    chk({tag, " penable_cycles"}, 32'(o.pen), 32'(v.exp_pen));
    chk({tag, " rdata"}, o.rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(o.err), 32'(v.exp_err));
    chk({tag, " busy_in_resp"}, 32'(o.busy), 32'd1);
    chk({tag, " bus_stable"}, 32'(o.bus_bad), 32'd0);
    chk({tag, " stall_stable"}, 32'(o.stall_bad), 32'd0);
    chk({tag, " valid_after"}, 32'(o.after_valid), 32'd0);
    chk({tag, " ready_after"}, 32'(o.after_ready), 32'd1);
  endtask

  vec_t vecs[6];
  vec_t v;
  obs_t o;

  initial begin
    //         addr     wdata         wr waits prdata        err hold rdata         err lat psel pen
    vecs[0] = '{12'h004, 32'h1C008080, 1, 1, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 4, 3, 2};
    vecs[1] = '{12'h0F8, 32'h0,        0, 2, 32'h00000012, 0, 0, 32'h00000012, 0, 5, 4, 3};
    vecs[2] = '{12'h3FC, 32'h0,        0, 0, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1, 3, 2, 1};
    vecs[3] = '{12'h402, 32'h12345678, 0, 0, 32'h0,        0, 10, 32'h0,       1, 1, 0, 0};
    vecs[4] = '{12'h010, 32'hCAFEF00D, 1, 0, 32'h55AA55AA, 1, 2, 32'h0,        1, 3, 2, 1};
    vecs[5] = '{12'h800, 32'h0,        0, 3, 32'hA5A55A5A, 0, 1, 32'hA5A55A5A, 0, 6, 5, 4};
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_write_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    bus.PRDATA      = '0;
    bus.PREADY      = 1'b0;
    bus.PSLVERR     = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("reset ctrl {rdy,vld,err,busy,psel,pen,pwrite}",
        32'({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.busy_o, bus.PSEL, bus.PENABLE, bus.PWRITE}),
        32'b1000000);
    chk("reset paddr", 32'(bus.PADDR), 32'h0);
    chk("reset pwdata", bus.PWDATA, 32'h0);
    chk("reset rdata", bus.rsp_rdata_o, 32'h0);
    HRESETn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], o);
      check_txn($sformatf("vec%0d", i), vecs[i], o);
    end

    for (int i = 0; i < 40; i++) begin
      v.addr = 12'($urandom);
      if ($urandom_range(0, 4) != 0) v.addr[1:0] = 2'b00;
      v.wdata  = $urandom;
      v.write  = 1'($urandom);
      v.waits  = $urandom_range(0, 3);
      v.prdata = $urandom;
      v.slverr = 1'($urandom);
      v.hold   = $urandom_range(0, 3);
      v = model(v);
      run_txn(v, o);
      check_txn($sformatf("rand%0d", i), v, o);
    end

    // Reset during ACCESS: bus drops without waiting for a clock edge, response is lost
    @(negedge HCLK);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 12'h020;
    bus.req_write_i = 1'b0;
    @(negedge HCLK);
    bus.req_valid_i = 1'b0;
    bus.PREADY = 1'b0;
    @(negedge HCLK);
    chk("rst_mid in_access", 32'({bus.PSEL, bus.PENABLE}), 32'b11);
    #2 HRESETn = 1'b0;
    #1 chk("rst_mid psel_penable", 32'({bus.PSEL, bus.PENABLE}), 32'b00);
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus.rsp_ready_i = 1'b1;
    repeat (2) @(negedge HCLK);
    chk("rst_mid ready_valid_busy", 32'({bus.req_ready_o, bus.rsp_valid_o, bus.busy_o}), 32'b100);
    bus.rsp_ready_i = 1'b0;

`ifdef APB_MST_TIMEOUT_EN
    v = '{12'h040, 32'h0, 0, 100, 32'h0, 0, 1, 32'hDEADBEEF, 1, 6, 5, 4};
    run_txn(v, o);
    check_txn("timeout_abort", v, o);
    v = '{12'h044, 32'h0, 0, 3, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 6, 5, 4};
    run_txn(v, o);
    check_txn("timeout_ready_wins", v, o);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/apb_soc_ctrl_master.md
Name: apb_soc_ctrl_master

Overview:
- Single-outstanding APB3 initiator that turns a simple valid/ready command stream into APB transactions.
- Intended users are the debug/JTAG command path and boot sequencer, driving soc-control-style register slaves: 12-bit address, PREADY-stalled, PSLVERR-reporting.
- Returns read data and error status through a separate valid/ready response channel.

Parameters:
- APB_ADDR_WIDTH, 12, width of req_addr_i and PADDR.
- TIMEOUT_CYCLES, 255, ACCESS-phase cycles without PREADY before abort. Used only with APB_MST_TIMEOUT_EN.

Ports:
- HCLK  input  1  clock.
- HRESETn  input  1  asynchronous active-low reset.
- req_valid_i  input  1  command valid.
- req_ready_o  output  1  command accepted when high together with req_valid_i.
- req_addr_i  input  APB_ADDR_WIDTH  byte address.
- req_wdata_i  input  32  write data.
- req_write_i  input  1  1=write, 0=read.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumed.
- rsp_rdata_o  output  32  read data; 0 for writes.
- rsp_err_o  output  1  PSLVERR, misalignment or timeout.
- busy_o  output  1  high whenever FSM is not IDLE.
- PADDR  output  APB_ADDR_WIDTH  APB address.
- PWDATA  output  32  APB write data.
- PWRITE  output  1  APB direction.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PRDATA  input  32  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB error.

Behaviour:
- Clock/reset: one clock HCLK; HRESETn asynchronous, active-low. All outputs are registered.
- Reset values: state IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; busy_o=0; PSEL=0; PENABLE=0; PWRITE=0; PADDR=0; PWDATA=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready_o=1.
  - On req_valid_i, capture addr/wdata/write and drop req_ready_o.
  - If req_addr_i[1:0]!=0: go to RESP with rsp_err_o=1, rsp_rdata_o=0. No APB cycle is issued.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA driven from captured values. Next state ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PADDR/PWDATA/PWRITE held stable until PREADY is sampled high.
  - On PREADY=1:
    - rsp_rdata_o = PWRITE ? 0 : PRDATA.
    - rsp_err_o = PSLVERR.
    - PSEL and PENABLE go 0 next cycle; go to RESP.
  - PSLVERR and PRDATA are ignored while PREADY=0.
- RESP: rsp_valid_o=1.
  - rsp_rdata_o and rsp_err_o are held until rsp_valid_o&&rsp_ready_i.
  - Then go to IDLE with rsp_valid_o=0 and req_ready_o=1.
  - A new request is never accepted in the same cycle as the response handshake (one idle cycle minimum).
- Latency: request accept edge at N. PSEL rises at N+1; PENABLE rises at N+2. With zero-wait PREADY, rsp_valid_o rises at N+3.
- Bus idle state: PSEL=0 and PENABLE=0 in IDLE and RESP. PADDR/PWDATA keep their last value; no toggling while idle.
- Back-pressure: rsp_ready_i held low stalls indefinitely in RESP. No further APB traffic occurs while stalled.
- Reset mid-transaction: PSEL/PENABLE drop asynchronously; any pending response is discarded.

Optional Feature:
- Macro: APB_MST_TIMEOUT_EN.
- Defined:
  - 8-bit counter cleared on entering ACCESS, incremented each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES: drop PSEL/PENABLE and go to RESP with rsp_err_o=1, rsp_rdata_o=32'hDEADBEEF.
  - PREADY arriving in the same cycle as expiry wins; this is a normal completion.
- Undefined: no counter; ACCESS waits forever for PREADY.

Test Plan:
- Write: req addr=0x004, wdata=0x1C008080, write=1, slave with 1 wait state -> PSEL high 3 cycles, PENABLE high 2 cycles, PWDATA=0x1C008080 stable throughout; rsp_err_o=0, rsp_rdata_o=0.
- Read: req addr=0x0F8, slave returns PRDATA=0x00000012 with PREADY after 2 waits -> rsp_rdata_o=0x00000012, rsp_err_o=0.
- Slave error: read addr=0x3FC, slave returns PSLVERR=1, PRDATA=0xDEADBEEF -> rsp_err_o=1, rsp_rdata_o=0xDEADBEEF.
- Misalignment and back-pressure:
  - Misaligned addr=0x402 -> no PSEL activity, rsp_err_o=1 one cycle after accept.
  - Hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o/data stable, req_ready_o=0 throughout.
- Reset mid-operation: assert HRESETn=0 during ACCESS -> PSEL=PENABLE=0 immediately, req_ready_o=1 after release, rsp_valid_o=0.
- Timeout (APB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0xDEADBEEF.
  - PREADY=1 on the 4th cycle -> normal completion.
